// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined shifter.
//   shift_mode_e : operation codes carried on the Mode port
//   is_rotate()  : true for the two rotate codes
//   ceilDiv()    : integer ceiling division used to spread shift levels over stages
package shifter_pkg;

  typedef enum logic [2:0] {
    SLL = 3'b000,
    SRL = 3'b001,
    SRA = 3'b010,
    ROL = 3'b011,
    ROR = 3'b100
  } shift_mode_e;

  function automatic logic is_rotate(input logic [2:0] mode);
    return (mode == ROL) || (mode == ROR);
  endfunction

  // A zero or negative denominator only happens with an illegal Stages value,
  // which the top level rejects at elaboration; avoid dividing by zero first.
  function automatic int ceilDiv(input int num, input int den);
    if (den < 1) return num;
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/shifter_stage.sv
// Combinational slice of the shifter covering levels FirstLevel..LastLevel.
// Level k moves the operand by 2^k positions when amount[k] is set.
// When FirstLevel > LastLevel the slice has no levels and passes everything through.
//   dataIn / dataOut   : operand before / after this slice
//   amount             : full shift distance; only this slice's bits act here
//   mode               : operation code (shift_mode_e encoding)
//   shOutIn / shOutOut : running "last bit shifted out" candidate
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int BitWidth   = 8,
  parameter int FirstLevel = 0,
  parameter int LastLevel  = 0
) (
  input  logic [BitWidth-1:0]         dataIn,
  input  logic [$clog2(BitWidth)-1:0] amount,
  input  logic [2:0]                  mode,
  input  logic                        shOutIn,
  output logic [BitWidth-1:0]         dataOut,
  output logic                        shOutOut
);

  localparam logic [BitWidth-1:0] LsbOne = BitWidth'(1);

  // Bits of amount outside this slice belong to other stages.
  logic unusedAmount;
  assign unusedAmount = ^amount;

  // Levels are applied smallest first. Because each level only sees the operand
  // already moved by the lower levels, the bit that falls off the edge at the
  // highest active level is exactly the overall last bit shifted out, so the
  // candidate is simply overwritten each time a shift level fires. Rotates and
  // reserved codes never touch the candidate, which enters stage 0 as zero.
  always_comb begin
    dataOut  = dataIn;
    shOutOut = shOutIn;
    for (int k = FirstLevel; k <= LastLevel; k++) begin
      if (amount[k]) begin
        case (mode)
          SLL: begin
            shOutOut = |(dataOut & (LsbOne << (BitWidth - (1 << k))));
            dataOut  = dataOut << (1 << k);
          end
          SRL: begin
            shOutOut = |(dataOut & (LsbOne << ((1 << k) - 1)));
            dataOut  = dataOut >> (1 << k);
          end
          SRA: begin
            shOutOut = |(dataOut & (LsbOne << ((1 << k) - 1)));
            dataOut  = $unsigned($signed(dataOut) >>> (1 << k));
          end
          ROL: dataOut = (dataOut << (1 << k)) | (dataOut >> (BitWidth - (1 << k)));
          ROR: dataOut = (dataOut >> (1 << k)) | (dataOut << (BitWidth - (1 << k)));
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined shift/rotate unit with valid/ready handshakes on both sides.
// The log2(BitWidth) shift levels are spread over Stages register stages,
// ceil(levels/Stages) per stage with the last stage taking the remainder.
//   Clk, Rst           : clock, synchronous active-high reset
//   InValid / InReady  : input handshake (InReady is combinational)
//   Mode, ShAmount     : operation code and distance
//   dIN, TagIn         : operand and opaque tag
//   OutValid / OutReady: output handshake
//   dOUT, ShOut, TagOut: result, last bit shifted out, tag of the result
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int BitWidth = 8,
  parameter int Stages   = 1,
  parameter int TagWidth = 1
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        InValid,
  output logic                        InReady,
  input  logic [2:0]                  Mode,
  input  logic [$clog2(BitWidth)-1:0] ShAmount,
  input  logic [BitWidth-1:0]         dIN,
  input  logic [TagWidth-1:0]         TagIn,
  output logic                        OutValid,
  input  logic                        OutReady,
  output logic [BitWidth-1:0]         dOUT,
  output logic                        ShOut,
  output logic [TagWidth-1:0]         TagOut
);

  localparam int AmtWidth       = $clog2(BitWidth);
  localparam int NumLevels      = AmtWidth;
  localparam int LevelsPerStage = ceilDiv(NumLevels, Stages);

  if (BitWidth < 2 || (BitWidth & (BitWidth - 1)) != 0) begin : gBadWidth
    $error("pipelined_shifter: BitWidth must be a power of two and at least 2");
  end
  if (Stages < 1 || Stages > AmtWidth) begin : gBadStages
    $error("pipelined_shifter: Stages must lie in 1..clog2(BitWidth)");
  end

  // The whole pipe moves as one: either every stage loads or every stage
  // holds. Bubbles therefore keep their slot, and a full pipe can still take a
  // new operation in the same cycle the consumer takes the oldest one.
  logic advance;
  assign advance = !OutValid || OutReady;
  assign InReady = advance;

  for (genvar s = 0; s < Stages; s++) begin : gStage
    localparam int First   = s * LevelsPerStage;
    localparam int LastRaw = First + LevelsPerStage - 1;
    localparam int Last    = (LastRaw > NumLevels - 1) ? NumLevels - 1 : LastRaw;

    logic [BitWidth-1:0] stageData;
    logic [AmtWidth-1:0] stageAmount;
    logic [2:0]          stageMode;
    logic [TagWidth-1:0] stageTag;
    logic                stageShOut;
    logic                stageValid;
    logic [BitWidth-1:0] nextData;
    logic                nextShOut;

    logic [BitWidth-1:0] dataQ;
    logic [AmtWidth-1:0] amountQ;
    logic [2:0]          modeQ;
    logic [TagWidth-1:0] tagQ;
    logic                shOutQ;
    logic                validQ;

    if (s == 0) begin : gHead
      assign stageData   = dIN;
      assign stageAmount = ShAmount;
      assign stageMode   = Mode;
      assign stageTag    = TagIn;
      assign stageShOut  = 1'b0;
      assign stageValid  = InValid;
    end else begin : gBody
      assign stageData   = gStage[s-1].dataQ;
      assign stageAmount = gStage[s-1].amountQ;
      assign stageMode   = gStage[s-1].modeQ;
      assign stageTag    = gStage[s-1].tagQ;
      assign stageShOut  = gStage[s-1].shOutQ;
      assign stageValid  = gStage[s-1].validQ;
    end

    shifter_stage #(
      .BitWidth   (BitWidth),
      .FirstLevel (First),
      .LastLevel  (Last)
    ) uStage (
      .dataIn   (stageData),
      .amount   (stageAmount),
      .mode     (stageMode),
      .shOutIn  (stageShOut),
      .dataOut  (nextData),
      .shOutOut (nextShOut)
    );

    // Reset clears every field, not just the valid bit, so the output port
    // reads zero straight after reset and in-flight work is discarded.
    always_ff @(posedge Clk) begin
      if (Rst) begin
        validQ  <= 1'b0;
        dataQ   <= '0;
        amountQ <= '0;
        modeQ   <= '0;
        tagQ    <= '0;
        shOutQ  <= 1'b0;
      end else if (advance) begin
        validQ  <= stageValid;
        dataQ   <= nextData;
        amountQ <= stageAmount;
        modeQ   <= stageMode;
        tagQ    <= stageTag;
        shOutQ  <= nextShOut;
      end
    end
  end

  assign OutValid = gStage[Stages-1].validQ;
  assign dOUT     = gStage[Stages-1].dataQ;
  assign ShOut    = gStage[Stages-1].shOutQ;
  assign TagOut   = gStage[Stages-1].tagQ;

  // The final stage's amount and mode have no downstream consumer.
  logic unusedTail;
  assign unusedTail = ^{gStage[Stages-1].amountQ, gStage[Stages-1].modeQ};

endmodule
